// File: rtl/sd_pkg.sv
// Shared SD host constants and types.
//   SD_BUS_W       : system bus data/address width
//   MEM_OFFSET     : byte step of the bus address per transferred word
//   WB_CTI_CLASSIC : Wishbone cycle type for single classic cycles
//   WB_BTE_LINEAR  : Wishbone burst type (unused by classic cycles, driven to 0)
//   tx_fill_state_t: states of the TX filler FSM
package sd_pkg;

  localparam int unsigned SD_BUS_W       = 32;
  localparam logic [31:0] MEM_OFFSET     = 32'd4;
  localparam logic [2:0]  WB_CTI_CLASSIC = 3'b000;
  localparam logic [1:0]  WB_BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    DIS,
    IDLE,
    BUS
  } tx_fill_state_t;

endpackage

// File: rtl/sd_tx_fifo_sync.sv
// Single-clock show-ahead FIFO with registered status and head word.
//   clk, rst : clock, synchronous active-high reset
//   flush    : synchronous clear of contents (same effect as rst)
//   wr, d    : push request and data
//   rd       : pop request; ignored when empty
//   q        : head word, registered, valid while empty=0
//   full     : Depth words stored
//   empty    : no words stored
//   count    : number of words stored
module sd_tx_fifo_sync #(
  parameter  int unsigned Depth = 8,
  parameter  int unsigned Width = 32,
  localparam int unsigned PtrW  = $clog2(Depth),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [Width-1:0] d,
  input  logic             rd,
  output logic [Width-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [Width-1:0] q_q, q_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_rd    = rd & ~empty_q;
    // A push into a full FIFO is allowed only when a pop frees the slot in the same cycle.
    do_wr    = wr & (~full_q | do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    q_d      = q_q;

    if (do_wr) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PtrW'(1);

    if (do_wr && !do_rd) begin
      count_d = count_q + CntW'(1);
    end else if (!do_wr && do_rd) begin
      count_d = count_q - CntW'(1);
    end

    // Head register: the next stored word after a pop, or the pushed word when it
    // lands at the head (push into empty, or push+pop with a single word stored).
    if (do_rd) begin
      if (count_q == CntW'(1)) begin
        if (do_wr) q_d = d;
      end else begin
        q_d = mem_q[rd_ptr_d];
      end
    end else if (do_wr && empty_q) begin
      q_d = d;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      q_d      = '0;
    end

    full_d  = (count_d == CntW'(Depth));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      q_q      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      q_q      <= q_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= d;
  end

  assign q     = q_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/sd_fifo_tx_filler.sv
// TX-direction DMA filler: a read-only Wishbone master that fetches words from
// adr onward and pushes them into a local FIFO popped by the SD serial transmitter.
//   clk, rst          : clock, synchronous active-high reset
//   m_wb_*            : Wishbone classic master (read only, one cycle outstanding)
//   en, adr           : transfer enable and base byte address
//   rd, dat_o         : serial-side pop and show-ahead head word
//   full, empty       : FIFO status (registered)
//   underflow         : sticky flag, rd seen on an empty FIFO; cleared while en=0
module sd_fifo_tx_filler
  import sd_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  output logic [SD_BUS_W-1:0] m_wb_adr_o,
  output logic                m_wb_we_o,
  input  logic [SD_BUS_W-1:0] m_wb_dat_i,
  output logic                m_wb_cyc_o,
  output logic                m_wb_stb_o,
  input  logic                m_wb_ack_i,
  output logic [2:0]          m_wb_cti_o,
  output logic [1:0]          m_wb_bte_o,
  input  logic                en,
  input  logic [SD_BUS_W-1:0] adr,
  input  logic                rd,
  output logic [SD_BUS_W-1:0] dat_o,
  output logic                full,
  output logic                empty,
  output logic                underflow
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  tx_fill_state_t      state_q, state_d;
  logic                cyc_q, cyc_d;
  logic [SD_BUS_W-1:0] offset_q, offset_d;
  logic                underflow_q, underflow_d;
  logic                push, flush, slot_free;
  logic                fifo_full, fifo_empty;
  logic [CntW-1:0]     fifo_count;

  // A pop in the same cycle frees a slot, so a full FIFO being drained may start a fetch.
  assign slot_free = (fifo_count < CntW'(FIFO_DEPTH)) | (rd & ~fifo_empty);
  // Dropping en flushes on the very next edge, not one cycle later from DIS.
  assign flush     = ~en | (state_q == DIS);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    offset_d    = offset_q;
    underflow_d = underflow_q;
    push        = 1'b0;

    if (!en) begin
      state_d     = DIS;
      cyc_d       = 1'b0;
      offset_d    = '0;
      underflow_d = 1'b0;
    end else begin
      unique case (state_q)
        DIS: begin
          state_d     = IDLE;
          underflow_d = 1'b0;
        end
        IDLE: begin
          underflow_d = underflow_q | (rd & fifo_empty);
          if (slot_free) begin
            state_d = BUS;
            cyc_d   = 1'b1;
          end
        end
        BUS: begin
          underflow_d = underflow_q | (rd & fifo_empty);
          if (m_wb_ack_i) begin
            push     = 1'b1;
            cyc_d    = 1'b0;
            offset_d = offset_q + MEM_OFFSET;
            state_d  = IDLE;
          end
        end
        default: begin
          state_d = DIS;
          cyc_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DIS;
      cyc_q       <= 1'b0;
      offset_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      offset_q    <= offset_d;
      underflow_q <= underflow_d;
    end
  end

  sd_tx_fifo_sync #(
    .Depth (FIFO_DEPTH),
    .Width (SD_BUS_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .wr    (push),
    .d     (m_wb_dat_i),
    .rd    (rd),
    .q     (dat_o),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign m_wb_adr_o = adr + offset_q;
  assign m_wb_we_o  = 1'b0;
  assign m_wb_cyc_o = cyc_q;
  assign m_wb_stb_o = cyc_q;
  assign m_wb_cti_o = WB_CTI_CLASSIC;
  assign m_wb_bte_o = WB_BTE_LINEAR;
  assign full       = fifo_full;
  assign empty      = fifo_empty;
  assign underflow  = underflow_q;

endmodule
